// File: rtl/adc_scanner.sv
// adc_scanner: round-robin sequencer for the single-shot ADS1115 adc controller.
// Averages 2^AVG_SHIFT conversions per enabled channel and publishes one result per scan.
`timescale 1ns/1ps
module adc_scanner #(
   parameter logic [3:0]  CHANNEL_MASK   = 4'b1111,
   parameter int unsigned PERIOD_CYCLES  = 270000,
   parameter int unsigned AVG_SHIFT      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        run_i,
   output logic        adc_enable_o,
   output logic [1:0]  adc_channel_o,
   input  logic [15:0] adc_data_i,
   input  logic        adc_data_ready_i,
   output logic [15:0] ch0_o,
   output logic [15:0] ch1_o,
   output logic [15:0] ch2_o,
   output logic [15:0] ch3_o,
   output logic [3:0]  valid_o,
   output logic        scan_done_o,
   output logic [3:0]  timeout_o,
   output logic        busy_o
);

   localparam int unsigned AW      = 16 + AVG_SHIFT;
   localparam logic [23:0] PER_LD  = 24'(PERIOD_CYCLES - 1);
   localparam logic [23:0] TMO_MAX = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]  NSAMP   = 5'(1 << AVG_SHIFT);

   function automatic logic [1:0] lowest_ch(input logic [3:0] m);
      lowest_ch = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (m[i]) lowest_ch = 2'(i);
   endfunction

   localparam logic [1:0] FIRST_CH = lowest_ch(CHANNEL_MASK);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_REQ, S_REL, S_NEXT
   } state_t;

   state_t r_state, w_next;

   logic               r_enable, r_armed, r_skip, r_rel;
   logic               r_last, r_done, r_run_q;
   logic [1:0]         r_ch;
   logic [4:0]         r_cnt;
   logic [23:0]        r_tmo, r_per;
   logic signed [AW-1:0] r_acc;
   logic [15:0]        r_res [4];
   logic [3:0]         r_valid, r_timeout;

   logic               w_start, w_capture, w_tmo_hit, w_adv;
   logic               w_found;
   logic [1:0]         w_nch;
   logic signed [AW-1:0] w_samp, w_shift;
   logic [15:0]        w_avg;

   assign w_samp  = AW'(signed'(adc_data_i));
   assign w_shift = r_acc >>> AVG_SHIFT;
   assign w_avg   = w_shift[15:0];

   // next enabled channel above the current one; wraps to the lowest
   always_comb begin
      w_found = 1'b0;
      w_nch   = FIRST_CH;
      for (int i = 3; i >= 0; i--) begin
         if (CHANNEL_MASK[i] && (2'(i) > r_ch)) begin
            w_found = 1'b1;
            w_nch   = 2'(i);
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_tmo_hit = 1'b0;
      w_adv     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (run_i && (CHANNEL_MASK != 4'd0)) begin
               w_next  = S_REQ;
               w_start = 1'b1;
            end
         end
         S_WAIT: begin
            if (!run_i) begin
               w_next = S_IDLE;
            end else if (r_per == 24'd0) begin
               w_next  = S_REQ;
               w_start = 1'b1;
            end
         end
         S_REQ: begin
            if (r_armed && adc_data_ready_i) begin
               w_capture = 1'b1;
               w_next    = S_REL;
            end else if (r_tmo == TMO_MAX) begin
               w_tmo_hit = 1'b1;
               w_next    = S_REL;
            end
         end
         S_REL: begin
            if (r_rel) begin
               if (!run_i) begin
                  w_next = S_IDLE;
               end else if (r_skip || (r_cnt == NSAMP)) begin
                  w_next = S_NEXT;
                  w_adv  = 1'b1;
               end else begin
                  w_next = S_REQ;
               end
            end
         end
         S_NEXT: begin
            if (!r_last)    w_next = S_REQ;
            else if (run_i) w_next = S_WAIT;
            else            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_enable  <= 1'b0;
         r_armed   <= 1'b0;
         r_skip    <= 1'b0;
         r_rel     <= 1'b0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_run_q   <= 1'b0;
         r_ch      <= 2'd0;
         r_cnt     <= 5'd0;
         r_tmo     <= 24'd0;
         r_per     <= 24'd0;
         r_acc     <= '0;
         r_valid   <= 4'd0;
         r_timeout <= 4'd0;
         for (int i = 0; i < 4; i++) r_res[i] <= 16'd0;
      end else begin
         r_enable <= (w_next == S_REQ);
         r_run_q  <= run_i;
         r_rel    <= (r_state == S_REL) && !r_rel;
         r_done   <= w_adv && !w_found;
         if (w_start)              r_per <= PER_LD;
         else if (r_per != 24'd0)  r_per <= r_per - 24'd1;
         if (r_state == S_REQ) r_tmo <= r_tmo + 24'd1;
         else                  r_tmo <= 24'd0;
         // a stale ready from the last conversion must drop before it counts
         if (r_state != S_REQ)       r_armed <= 1'b0;
         else if (!adc_data_ready_i) r_armed <= 1'b1;
         if (run_i && !r_run_q) r_timeout <= 4'd0;
         if (r_state == S_IDLE) r_ch <= FIRST_CH;
         if (w_start) begin
            r_ch   <= FIRST_CH;
            r_acc  <= '0;
            r_cnt  <= 5'd0;
            r_skip <= 1'b0;
            r_last <= 1'b0;
         end
         if (w_capture) begin
            r_acc <= r_acc + w_samp;
            r_cnt <= r_cnt + 5'd1;
         end
         if (w_tmo_hit) begin
            r_skip          <= 1'b1;
            r_timeout[r_ch] <= 1'b1;
         end
         if (w_adv) begin
            if (!r_skip) begin
               r_res[r_ch]   <= w_avg;
               r_valid[r_ch] <= 1'b1;
            end
            r_ch   <= w_nch;
            r_last <= !w_found;
            r_acc  <= '0;
            r_cnt  <= 5'd0;
            r_skip <= 1'b0;
         end
      end
   end

   assign adc_enable_o  = r_enable;
   assign adc_channel_o = r_ch;
   assign ch0_o         = r_res[0];
   assign ch1_o         = r_res[1];
   assign ch2_o         = r_res[2];
   assign ch3_o         = r_res[3];
   assign valid_o       = r_valid;
   assign scan_done_o   = r_done;
   assign timeout_o     = r_timeout;
   assign busy_o        = (r_state == S_REQ) || (r_state == S_REL) ||
                          (r_state == S_NEXT);

endmodule
